// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: controller state encoding, opcode values
// (IR[15:12]) and ALU function (M) encodings. Also imported by the
// MU0 datapath benches.
package mu0_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  localparam logic [1:0] M_Y   = 2'b00;  // pass Y
  localparam logic [1:0] M_ADD = 2'b01;  // X + Y
  localparam logic [1:0] M_INC = 2'b10;  // X + 1
  localparam logic [1:0] M_SUB = 2'b11;  // X - Y

endpackage

// File: rtl/mu0_control.sv
// MU0 control unit: FETCH / EXEC / HALT state machine with a combinational
// output decode and a saturating retired-instruction counter.
// Ports:
//   Clk, Reset         clock, synchronous active-high reset
//   F, N, Z            opcode and Acc negative/zero flags from the datapath
//   Mem_Rdy            memory completes the current Rd/Wr this cycle
//   X_sel/Y_sel/Addr_sel, PC_En/IR_En/Acc_En, M   datapath controls
//   Rd, Wr             memory strobes
//   Halted             high while in HALT
//   Instr_Count        retired instructions (saturating)
module mu0_control
  import mu0_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [3:0]       F,
  input  logic             N,
  input  logic             Z,
  input  logic             Mem_Rdy,
  output logic             X_sel,
  output logic             Y_sel,
  output logic             Addr_sel,
  output logic             PC_En,
  output logic             IR_En,
  output logic             Acc_En,
  output logic [1:0]       M,
  output logic             Rd,
  output logic             Wr,
  output logic             Halted,
  output logic [CNT_W-1:0] Instr_Count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;  // EXEC finishes its instruction this cycle
  logic             take;    // jump condition met

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    take     = 1'b0;
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    Addr_sel = 1'b0;
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    Acc_En   = 1'b0;
    M        = M_Y;
    Rd       = 1'b0;
    Wr       = 1'b0;

    case (state_q)
      S_FETCH: begin
        // Read instruction at PC while PC <- PC + 1; loads only when
        // memory completes so a stalled fetch leaves PC/IR untouched.
        Rd    = 1'b1;
        X_sel = 1'b1;
        M     = M_INC;
        IR_En = Mem_Rdy;
        PC_En = Mem_Rdy;
        if (Mem_Rdy) state_d = S_EXEC;
      end
      S_EXEC: begin
        case (F)
          OP_LDA: begin
            Addr_sel = 1'b1;
            Rd       = 1'b1;
            M        = M_Y;
            Acc_En   = Mem_Rdy;
            retire   = Mem_Rdy;
          end
          OP_STA: begin
            Addr_sel = 1'b1;
            Wr       = 1'b1;
            retire   = Mem_Rdy;
          end
          OP_ADD, OP_SUB: begin
            Addr_sel = 1'b1;
            Rd       = 1'b1;
            M        = (F == OP_ADD) ? M_ADD : M_SUB;
            Acc_En   = Mem_Rdy;
            retire   = Mem_Rdy;
          end
          OP_JMP, OP_JGE, OP_JNE: begin
            take   = (F == OP_JMP) || (F == OP_JGE && !N) || (F == OP_JNE && !Z);
            Y_sel  = take;
            PC_En  = take;
            retire = 1'b1;
          end
          default: retire = 1'b1;  // STP and NOPs
        endcase
        if (retire) state_d = (F == OP_STP) ? S_HALT : S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Reset must not disturb the datapath or memory in the cycle it is applied.
    if (Reset) begin
      PC_En  = 1'b0;
      IR_En  = 1'b0;
      Acc_En = 1'b0;
      Rd     = 1'b0;
      Wr     = 1'b0;
    end

    cnt_d = (retire && cnt_q != '1) ? cnt_q + CNT_ONE : cnt_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Halted      = (state_q == S_HALT);
  assign Instr_Count = cnt_q;

endmodule

// File: doc/mu0_control.md
MU0_CONTROL -- requirements
Module: MU0_Control

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port F  input  4  opcode, taken from IR[15:12] in the datapath.
REQ-005 SHALL have ports N, Z  input  1 each  Acc negative / Acc zero flags from the datapath.
REQ-006 SHALL have port Mem_Rdy  input  1  memory completes the current Rd/Wr this cycle when high.
REQ-007 SHALL have ports X_sel, Y_sel, Addr_sel  output  1 each  datapath mux selects: X 0=Acc 1=PC; Y 0=Din 1=IR; Addr 0=PC 1=IR[11:0].
REQ-008 SHALL have ports PC_En, IR_En, Acc_En  output  1 each  datapath register load enables.
REQ-009 SHALL have port M  output  2  ALU function: 00=Y, 01=X+Y, 10=X+1, 11=X-Y.
REQ-010 SHALL have ports Rd, Wr  output  1 each  memory read / write strobes.
REQ-011 SHALL have port Halted  output  1  high while in HALT.
REQ-012 SHALL have port Instr_Count  output  CNT_W  number of retired instructions.

Function
REQ-013 SHALL implement the states FETCH, EXEC, HALT.
REQ-014 In FETCH, SHALL drive Addr_sel=0, Rd=1, IR_En=1, X_sel=1, M=10, PC_En=1, all other enables and Wr = 0.
REQ-015 FETCH SHALL go to EXEC when Mem_Rdy=1; otherwise it SHALL stay in FETCH.
REQ-016 In EXEC, outputs SHALL be decoded combinationally from F, N and Z; unlisted outputs SHALL be 0 and don't-care selects SHALL be 0.
REQ-017 F=0 (LDA) SHALL drive Addr_sel=1, Rd=1, Y_sel=0, M=00, Acc_En=1.
REQ-018 F=1 (STA) SHALL drive Addr_sel=1, X_sel=0, Wr=1.
REQ-019 F=2 (ADD) SHALL drive Addr_sel=1, Rd=1, X_sel=0, Y_sel=0, M=01, Acc_En=1; F=3 (SUB) SHALL be identical except M=11.
REQ-020 F=4 (JMP) SHALL drive Y_sel=1, M=00, PC_En=1.
REQ-021 F=5 (JGE) SHALL behave as JMP when N=0 and SHALL assert no enable when N=1.
REQ-022 F=6 (JNE) SHALL behave as JMP when Z=0 and SHALL assert no enable when Z=1.
REQ-023 F=7 (STP) SHALL assert no enable and SHALL go to HALT; F=8..F SHALL be NOPs (no enables, no Rd/Wr) returning to FETCH.
REQ-024 For LDA, STA, ADD and SUB with Mem_Rdy=0, EXEC SHALL hold with the same selects and Rd/Wr asserted, PC_En/IR_En/Acc_En forced 0, and no state change.
REQ-025 EXEC SHALL return to FETCH when the instruction completes: Mem_Rdy=1 for memory instructions, immediately for JMP/JGE/JNE/NOP.
REQ-026 Instr_Count SHALL increment by 1 on every EXEC completion including STP, SHALL saturate at all-ones, and SHALL not count wait cycles.
REQ-027 HALT SHALL be absorbing until Reset, with all enables, Rd and Wr at 0 and Halted=1.
REQ-028 Mem_Rdy SHALL be ignored in cycles where Rd=0 and Wr=0.
REQ-029 Rd and Wr SHALL never be high in the same cycle.

Reset
REQ-030 When Reset=1 at a rising edge, state SHALL become FETCH and Instr_Count SHALL become 0, regardless of state or pending wait.
REQ-031 While Reset=1, PC_En, IR_En, Acc_En, Rd and Wr SHALL be forced to 0.
REQ-032 After reset release, the first cycle SHALL be a FETCH at the datapath's reset PC.

Structure
REQ-033 State encoding, opcode constants (LDA..STP) and M encodings SHALL live in shared package mu0_pkg, also used by MU0_Datapath benches.
REQ-034 SHALL be a single FSM module with combinational output decode and no sub-module.
REQ-035 State and Instr_Count SHALL be the only registers.

Verification
REQ-036 Reset, then Mem_Rdy=1 with F=0: cycle 1 SHALL show FETCH outputs (Rd=1, IR_En=1, PC_En=1, M=10); cycle 2 SHALL show Addr_sel=1, Acc_En=1, M=00; Instr_Count SHALL read 1.
REQ-037 FETCH with Mem_Rdy=0 for 3 cycles then 1 SHALL hold Rd=1 with IR_En=PC_En=0 for 3 cycles, then enter EXEC once.
REQ-038 F=5 with N=1 then F=5 with N=0 SHALL give PC_En=0 then PC_En=1 with Y_sel=1, M=00; F=6 with Z=1 / Z=0 SHALL behave likewise.
REQ-039 F=1 with Mem_Rdy=0 for 2 cycles SHALL hold Wr=1, Addr_sel=1, X_sel=0 for 3 cycles total, then return to FETCH, with Rd never high.
REQ-040 F=7 SHALL set Halted=1 and keep all strobes 0 for 10+ cycles regardless of F and Mem_Rdy; Reset SHALL then give FETCH with Instr_Count=0.
REQ-041 Reset asserted mid-wait in EXEC(ADD) SHALL force enables to 0 that cycle and FETCH next; CNT_W=2 running 5 NOPs SHALL saturate Instr_Count at 3.
